dmem_responder: RTL and testbench

Multicycle data-memory responder that serves load/store requests from the core's memory port over a valid/ready request channel and a valid/ready response channel. It sits between the control unit and the data storage, replacing the zero-latency array with a handshaked slave that has configurable wait states. Stores use 4-bit byte enables over a lane-replicated 32-bit write word. Loads return the raw aligned word; the core's load-extract logic selects and extends the bytes.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_bank.sv | 41 ++++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Holds the FSM encoding, bus field widths and the latched request payload.
package dmem_responder_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WE_W   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam logic [WE_W-1:0] WE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [WE_W-1:0]   we;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // Unsigned word-index bound check; no wrap-around.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                          input int unsigned     depth);
        return {2'b00, idx} < depth;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready bus between the core memory port and the responder.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [WE_W-1:0]   req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_bank.sv
// Word storage with byte-lane synchronous write and a registered read port.
// The read register doubles as the response data: zero for writes, cleared on handshake.
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           access,
    input  logic [WE_W-1:0]                we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           rd_clr,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (access) begin
            for (int i = 0; i < int'(WE_W); i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (access) begin
            rdata <= (we == WE_NONE) ? mem[addr] : '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// performs the access and holds the response until the core takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned BANK_AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    dmem_req_t         incoming_c, acc_req_c;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              enter_resp_c, in_range_c, access_c, rd_clr_c;
    logic              unused_addr_lsb;

    assign incoming_c      = '{index: bus.req_addr[ADDR_W-1:2],
                               we:    bus.req_we,
                               wdata: bus.req_wdata};
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // Next-state, counter and response-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        enter_resp_c = 1'b0;
        access_c     = 1'b0;
        rd_clr_c     = 1'b0;
        // With no wait states the access happens on the accept edge itself.
        acc_req_c    = (state_q == ST_IDLE) ? incoming_c : req_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_d = incoming_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    rd_clr_c     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_range_c = idx_in_range(acc_req_c.index, DEPTH_WORDS);
        if (enter_resp_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = !in_range_c;
            access_c     = in_range_c;
            rd_clr_c     = !in_range_c;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .access (access_c),
        .we     (acc_req_c.we),
        .addr   (acc_req_c.index[BANK_AW-1:0]),
        .wdata  (acc_req_c.wdata),
        .rd_clr (rd_clr_c),
        .rdata  (bus.resp_rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with three wait-state configurations (2, 4, 0).
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    int          sel;
    logic        req_valid;
    logic        resp_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;

    logic        obs_req_ready;
    logic        obs_resp_valid;
    logic        obs_err;
    logic [31:0] obs_rdata;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_w2();
    dmem_responder_if bus_w4();
    dmem_responder_if bus_w0();

    assign bus_w2.req_valid  = req_valid && (sel == 0);
    assign bus_w2.resp_ready = resp_ready && (sel == 0);
    assign bus_w2.req_addr   = req_addr;
    assign bus_w2.req_we     = req_we;
    assign bus_w2.req_wdata  = req_wdata;

    assign bus_w4.req_valid  = req_valid && (sel == 1);
    assign bus_w4.resp_ready = resp_ready && (sel == 1);
    assign bus_w4.req_addr   = req_addr;
    assign bus_w4.req_we     = req_we;
    assign bus_w4.req_wdata  = req_wdata;

    assign bus_w0.req_valid  = req_valid && (sel == 2);
    assign bus_w0.resp_ready = resp_ready && (sel == 2);
    assign bus_w0.req_addr   = req_addr;
    assign bus_w0.req_we     = req_we;
    assign bus_w0.req_wdata  = req_wdata;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .bus(bus_w2.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .reset(reset), .bus(bus_w4.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .bus(bus_w0.slave));

    always_comb begin
        case (sel)
            1: begin
                obs_req_ready  = bus_w4.req_ready;
                obs_resp_valid = bus_w4.resp_valid;
                obs_rdata      = bus_w4.resp_rdata;
                obs_err        = bus_w4.resp_err;
            end
            2: begin
                obs_req_ready  = bus_w0.req_ready;
                obs_resp_valid = bus_w0.resp_valid;
                obs_rdata      = bus_w0.resp_rdata;
                obs_err        = bus_w0.resp_err;
            end
            default: begin
                obs_req_ready  = bus_w2.req_ready;
                obs_resp_valid = bus_w2.resp_valid;
                obs_rdata      = bus_w2.resp_rdata;
                obs_err        = bus_w2.resp_err;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Ends on a negedge; bounded wait for the selected responder to be ready.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!obs_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(obs_req_ready), 32'd1);
    endtask

    // One request: latency measured in negedges after the accept edge.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [3:0] we,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int hold);
        int lat;
        wait_ready(tag);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!obs_resp_valid && lat < 40);
        check_eq({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, obs_rdata, exp_rdata);
        check_eq({tag, "_err"},   32'(obs_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(obs_resp_valid), 32'd1);
            check_eq({tag, "_hold_rdata"}, obs_rdata, exp_rdata);
            check_eq({tag, "_hold_err"},   32'(obs_err), 32'(exp_err));
            check_eq({tag, "_hold_ready"}, 32'(obs_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_post_ready"}, 32'(obs_req_ready), 32'd1);
        check_eq({tag, "_post_valid"}, 32'(obs_resp_valid), 32'd0);
        check_eq({tag, "_post_rdata"}, obs_rdata, 32'd0);
    endtask

    // Back-to-back reads with resp_ready held high for 20 cycles.
    task automatic throughput(input string tag, input int exp_count);
        int acc;
        int rsp;
        acc = 0;
        rsp = 0;
        wait_ready(tag);
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        req_we     = 4'b0000;
        resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (obs_req_ready)  acc++;
            if (obs_resp_valid) rsp++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq({tag, "_accepts"},   32'(acc), 32'(exp_count));
        check_eq({tag, "_responses"}, 32'(rsp), 32'(exp_count));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sel        = 0;
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        req_we     = 4'b0000;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_eq("rst_req_ready",  32'(obs_req_ready), 32'd0);
            check_eq("rst_resp_valid", 32'(obs_resp_valid), 32'd0);
        end
        check_eq("rst_rdata", obs_rdata, 32'd0);
        check_eq("rst_err",   32'(obs_err), 32'd0);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check_eq("rel_req_ready", 32'(obs_req_ready), 32'd1);

        // WAIT_CYCLES=2: write/read, byte lanes, out of range
        do_txn("wr10",   32'h10, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 3, 0);
        do_txn("rd10",   32'h10, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0);
        do_txn("wr20",   32'h20, 4'b1111, 32'h11223344, 32'h0,        1'b0, 3, 0);
        do_txn("wr20b2", 32'h20, 4'b0100, 32'hAAAAAAAA, 32'h0,        1'b0, 3, 0);
        do_txn("rd20",   32'h20, 4'b0000, 32'h0,        32'h11AA3344, 1'b0, 3, 0);
        do_txn("wr00",   32'h0,  4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 3, 0);
        do_txn("wr_oor", 32'h1000, 4'b1111, 32'h12345678, 32'h0,      1'b1, 3, 0);
        do_txn("rd_oor", 32'h1000, 4'b0000, 32'h0,      32'h0,        1'b1, 3, 0);
        do_txn("rd00",   32'h0,  4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0);
        do_txn("rd_top", 32'hFFFFFFFC, 4'b0000, 32'h0,  32'h0,        1'b1, 3, 0);
        do_txn("bp_rd10", 32'h10, 4'b0000, 32'h0,       32'hDEADBEEF, 1'b0, 3, 5);

        // WAIT_CYCLES=4: reset during WAIT drops the pending write
        sel = 1;
        do_txn("w4_wr08", 32'h8, 4'b1111, 32'h12345678, 32'h0, 1'b0, 5, 0);
        wait_ready("w4_rstwr");
        req_valid = 1'b1;
        req_addr  = 32'h8;
        req_we    = 4'b1111;
        req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", 32'(obs_resp_valid), 32'd0);
        check_eq("midrst_ready", 32'(obs_req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_txn("w4_rd08", 32'h8, 4'b0000, 32'h0, 32'h12345678, 1'b0, 5, 0);

        // Committed writes in the other instance survive reset
        sel = 0;
        do_txn("post_rd10", 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        do_txn("post_rd20", 32'h20, 4'b0000, 32'h0, 32'h11AA3344, 1'b0, 3, 0);

        // WAIT_CYCLES=0: single-cycle latency and throughput
        sel = 2;
        do_txn("w0_wr04", 32'h4, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0, 1, 0);
        do_txn("w0_rd04", 32'h4, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0, 1, 0);
        throughput("w0_tput", 10);
        sel = 0;
        throughput("w2_tput", 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
